// File: rtl/hdmi_pkg.sv
// Shared HDMI data-island constants and the BCH ECC step used by TX and RX.
// The LFSR folds one bit per call, LSB of the state is the feedback tap.
package hdmi_pkg;

    localparam logic [7:0] ECC_POLY   = 8'b10000011;
    localparam int         PKT_PIXELS = 32;
    localparam int         HDR_BITS   = 24;
    localparam int         SUB_BITS   = 56;
    localparam int         NUM_SUBS   = 4;

    function automatic logic [7:0] next_ecc(
        input logic [7:0] e,
        input logic       b,
        input logic [7:0] poly
    );
        return (e >> 1) ^ ((e[0] ^ b) ? poly : 8'h00);
    endfunction

endpackage

// File: rtl/packet_disassembler_if.sv
// Data-island packet bus: decoded pixel stream in, reassembled packet out.
// master = TERC4 decoder side, slave = packet disassembler.
interface packet_disassembler_if;
    import hdmi_pkg::*;

    logic                               data_island_period;
    logic [8:0]                         packet_data;
    logic [HDR_BITS-1:0]                header;
    logic [NUM_SUBS-1:0][SUB_BITS-1:0]  sub;
    logic [4:0]                         ecc_error;
    logic                               packet_valid;
    logic [4:0]                         counter;

    modport master (
        output data_island_period, packet_data,
        input  header, sub, ecc_error, packet_valid, counter
    );

    modport slave (
        input  data_island_period, packet_data,
        output header, sub, ecc_error, packet_valid, counter
    );

endinterface

// File: rtl/bch_block_checker.sv
// Reassembles one BCH block (header or subpacket) and checks its parity byte.
// Data shifts in LSB-first; parity is collected after the data cycles.
module bch_block_checker
    import hdmi_pkg::*;
#(
    parameter int         BITS_PER_CYCLE = 1,
    parameter int         DATA_BITS      = 24,
    parameter logic [7:0] POLY           = ECC_POLY
) (
    input  logic                      clk_pixel,
    input  logic                      reset,
    input  logic                      en,
    input  logic [4:0]                counter,
    input  logic [BITS_PER_CYCLE-1:0] bits,
    output logic [DATA_BITS-1:0]      data,
    output logic                      mismatch
);

    localparam int DATA_CYCLES = DATA_BITS / BITS_PER_CYCLE;

    logic [DATA_BITS-1:0] data_q, data_d;
    logic [7:0]           ecc_q, ecc_d;
    logic [7:0]           par_q, par_d;
    logic                 in_data;

    assign in_data = int'(counter) < DATA_CYCLES;

    always_comb begin
        data_d = data_q;
        ecc_d  = ecc_q;
        par_d  = par_q;
        if (en) begin
            if (in_data) begin
                data_d = {bits, data_q[DATA_BITS-1:BITS_PER_CYCLE]};
                ecc_d  = (counter == '0) ? 8'h00 : ecc_q;
                for (int i = 0; i < BITS_PER_CYCLE; i++) begin
                    ecc_d = next_ecc(ecc_d, bits[i], POLY);
                end
            end else begin
                par_d = {bits, par_q[7:BITS_PER_CYCLE]};
            end
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            data_q <= '0;
            ecc_q  <= '0;
            par_q  <= '0;
        end else begin
            data_q <= data_d;
            ecc_q  <= ecc_d;
            par_q  <= par_d;
        end
    end

    // Only meaningful on the last pixel, when par_d holds the whole byte.
    assign data     = data_q;
    assign mismatch = (ecc_q != par_d);

endmodule

// File: rtl/packet_disassembler.sv
// HDMI RX data-island packet disassembler: rebuilds header and subpackets
// from the TERC4-decoded pixel stream and flags BCH parity mismatches.
module packet_disassembler #(
    parameter logic [7:0] ECC_POLY         = hdmi_pkg::ECC_POLY,
    parameter bit         DROP_BAD_PACKETS = 1'b0
) (
    input  logic                  clk_pixel,
    input  logic                  reset,
    packet_disassembler_if.slave  bus
);
    import hdmi_pkg::*;

    logic [4:0]                        counter_q, counter_d;
    logic [HDR_BITS-1:0]               header_q, header_d;
    logic [NUM_SUBS-1:0][SUB_BITS-1:0] sub_q, sub_d;
    logic [4:0]                        ecc_error_q, ecc_error_d;
    logic                              packet_valid_q, packet_valid_d;

    logic [HDR_BITS-1:0]               hdr_data;
    logic                              hdr_err;
    logic [NUM_SUBS-1:0][SUB_BITS-1:0] sub_data;
    logic [NUM_SUBS-1:0]               sub_err;
    logic                              island;
    logic                              last;
    logic                              bad;

    assign island = bus.data_island_period;
    assign last   = island && (counter_q == 5'(PKT_PIXELS - 1));
    assign bad    = hdr_err || (|sub_err);

    bch_block_checker #(
        .BITS_PER_CYCLE (1),
        .DATA_BITS      (HDR_BITS),
        .POLY           (ECC_POLY)
    ) u_hdr (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .en        (island),
        .counter   (counter_q),
        .bits      (bus.packet_data[0]),
        .data      (hdr_data),
        .mismatch  (hdr_err)
    );

    for (genvar i = 0; i < NUM_SUBS; i++) begin : g_sub
        bch_block_checker #(
            .BITS_PER_CYCLE (2),
            .DATA_BITS      (SUB_BITS),
            .POLY           (ECC_POLY)
        ) u_sub (
            .clk_pixel (clk_pixel),
            .reset     (reset),
            .en        (island),
            .counter   (counter_q),
            .bits      ({bus.packet_data[5+i], bus.packet_data[1+i]}),
            .data      (sub_data[i]),
            .mismatch  (sub_err[i])
        );
    end

    // Leaving the island throws away any partial packet by restarting at 0.
    always_comb begin
        counter_d      = island ? counter_q + 5'd1 : 5'd0;
        header_d       = header_q;
        sub_d          = sub_q;
        ecc_error_d    = ecc_error_q;
        packet_valid_d = 1'b0;
        if (last) begin
            ecc_error_d    = {hdr_err, sub_err};
            packet_valid_d = !(DROP_BAD_PACKETS && bad);
            if (!(DROP_BAD_PACKETS && bad)) begin
                header_d = hdr_data;
                sub_d    = sub_data;
            end
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            counter_q      <= '0;
            header_q       <= '0;
            sub_q          <= '0;
            ecc_error_q    <= '0;
            packet_valid_q <= 1'b0;
        end else begin
            counter_q      <= counter_d;
            header_q       <= header_d;
            sub_q          <= sub_d;
            ecc_error_q    <= ecc_error_d;
            packet_valid_q <= packet_valid_d;
        end
    end

    assign bus.counter      = counter_q;
    assign bus.header       = header_q;
    assign bus.sub          = sub_q;
    assign bus.ecc_error    = ecc_error_q;
    assign bus.packet_valid = packet_valid_q;

endmodule

// File: tb/tb_packet_disassembler.sv
// Randomized bench for packet_disassembler against a packet-level model.
// Runs a pass-through instance and a drop-bad-packets instance side by side.
module tb_packet_disassembler;

    typedef logic [31:0][8:0]  words_t;
    typedef logic [3:0][55:0]  subs_t;

    localparam logic [7:0] POLY = 8'b10000011;

    logic clk_pixel = 1'b0;
    logic reset     = 1'b1;

    always #5 clk_pixel = ~clk_pixel;

    packet_disassembler_if bus ();
    packet_disassembler_if bus_d ();

    assign bus_d.data_island_period = bus.data_island_period;
    assign bus_d.packet_data        = bus.packet_data;

    packet_disassembler #(.DROP_BAD_PACKETS(1'b0)) dut (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .bus       (bus)
    );

    packet_disassembler #(.DROP_BAD_PACKETS(1'b1)) dut_drop (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .bus       (bus_d)
    );

    int vectors     = 0;
    int miscompares = 0;

    int cyc       = 0;
    int pulse_cnt = 0;
    int dpulse_cnt = 0;
    int pulse_cyc[$];

    always @(posedge clk_pixel) begin
        cyc++;
        if (bus.packet_valid === 1'b1) begin
            pulse_cnt++;
            pulse_cyc.push_back(cyc);
        end
        if (bus_d.packet_valid === 1'b1) dpulse_cnt++;
    end

    // expected contents of the last packet and of the drop instance
    logic [23:0] m_hdr;
    subs_t       m_sub;
    logic [4:0]  m_err;
    logic [23:0] drop_hdr;
    subs_t       drop_sub;

    task automatic step();
        @(posedge clk_pixel);
        #1;
    endtask

    function automatic logic [7:0] ref_ecc(input logic [63:0] bits, input int n);
        logic [7:0] e;
        logic       fb;
        e = 8'h00;
        for (int i = 0; i < n; i++) begin
            fb = e[0] ^ bits[i];
            e  = e >> 1;
            if (fb) e = e ^ POLY;
        end
        return e;
    endfunction

    function automatic words_t encode(input logic [23:0] hdr, input subs_t s);
        words_t      w;
        logic [31:0] hp;
        logic [63:0] sp;
        w  = '0;
        hp = {ref_ecc({40'h0, hdr}, 24), hdr};
        for (int c = 0; c < 32; c++) w[c][0] = hp[c];
        for (int i = 0; i < 4; i++) begin
            sp = {ref_ecc({8'h0, s[i]}, 56), s[i]};
            for (int c = 0; c < 32; c++) begin
                w[c][1+i] = sp[2*c];
                w[c][5+i] = sp[2*c+1];
            end
        end
        return w;
    endfunction

    // Packet-level view of what the receiver should report for a pixel stream.
    task automatic decode(input words_t w, output logic [23:0] hdr,
                          output subs_t s, output logic [4:0] err);
        logic [31:0] hp;
        logic [63:0] sp;
        for (int c = 0; c < 32; c++) hp[c] = w[c][0];
        hdr    = hp[23:0];
        err[4] = ref_ecc({40'h0, hp[23:0]}, 24) != hp[31:24];
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < 32; c++) begin
                sp[2*c]   = w[c][1+i];
                sp[2*c+1] = w[c][5+i];
            end
            s[i]   = sp[55:0];
            err[i] = ref_ecc({8'h0, sp[55:0]}, 56) != sp[63:56];
        end
    endtask

    function automatic subs_t rand_subs();
        subs_t s;
        for (int i = 0; i < 4; i++) s[i] = 56'({$urandom, $urandom});
        return s;
    endfunction

    task automatic model_reset();
        m_hdr    = '0;
        m_sub    = '0;
        m_err    = '0;
        drop_hdr = '0;
        drop_sub = '0;
    endtask

    task automatic run_packet(input words_t w);
        for (int c = 0; c < 32; c++) begin
            bus.data_island_period = 1'b1;
            bus.packet_data        = w[c];
            step();
        end
        decode(w, m_hdr, m_sub, m_err);
        if (m_err == 5'b0) begin
            drop_hdr = m_hdr;
            drop_sub = m_sub;
        end
    endtask

    task automatic test_reset();
        bus.data_island_period = 1'b0;
        bus.packet_data        = '0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        model_reset();
        step();
        vectors++;
        if (bus.counter !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_counter got %0d want 0", bus.counter);
        end
        vectors++;
        if (bus.header !== 24'h0 || bus.sub !== '0) begin
            miscompares++;
            $display("FAIL reset_data got hdr %h sub %h want 0", bus.header, bus.sub);
        end
        vectors++;
        if (bus.ecc_error !== 5'b0 || bus.packet_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags got err %b valid %b want 0 0",
                     bus.ecc_error, bus.packet_valid);
        end
        vectors++;
        if (bus_d.header !== 24'h0 || bus_d.packet_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_drop got hdr %h valid %b want 0 0",
                     bus_d.header, bus_d.packet_valid);
        end
    endtask

    task automatic test_null_packet();
        words_t w;
        w = '0;
        for (int c = 0; c < 31; c++) begin
            bus.data_island_period = 1'b1;
            bus.packet_data        = w[c];
            step();
        end
        vectors++;
        if (bus.packet_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL null_early got valid %b want 0", bus.packet_valid);
        end
        vectors++;
        if (bus.counter !== 5'd31) begin
            miscompares++;
            $display("FAIL null_counter got %0d want 31", bus.counter);
        end
        bus.packet_data = w[31];
        step();
        decode(w, m_hdr, m_sub, m_err);
        drop_hdr = m_hdr;
        drop_sub = m_sub;
        // island falls right after the final pixel; packet still comes out
        bus.data_island_period = 1'b0;
        vectors++;
        if (bus.packet_valid !== 1'b1 || bus.header !== 24'h0 || bus.ecc_error !== 5'b0) begin
            miscompares++;
            $display("FAIL null_packet got valid %b hdr %h err %b want 1 000000 00000",
                     bus.packet_valid, bus.header, bus.ecc_error);
        end
        step();
        vectors++;
        if (bus.packet_valid !== 1'b0 || bus.counter !== 5'd0) begin
            miscompares++;
            $display("FAIL null_pulse_width got valid %b cnt %0d want 0 0",
                     bus.packet_valid, bus.counter);
        end
    endtask

    task automatic test_golden();
        subs_t  s;
        words_t w;
        s    = '0;
        s[0] = 56'h00000000001A2B;
        w    = encode(24'h0D0282, s);
        run_packet(w);
        vectors++;
        if (bus.header !== 24'h0D0282 || bus.sub !== s) begin
            miscompares++;
            $display("FAIL golden_data got hdr %h sub0 %h want 0d0282 %h",
                     bus.header, bus.sub[0], s[0]);
        end
        vectors++;
        if (bus.ecc_error !== 5'b0 || bus.packet_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL golden_flags got err %b valid %b want 00000 1",
                     bus.ecc_error, bus.packet_valid);
        end
        vectors++;
        if (bus_d.packet_valid !== 1'b1 || bus_d.header !== 24'h0D0282) begin
            miscompares++;
            $display("FAIL golden_drop got valid %b hdr %h want 1 0d0282",
                     bus_d.packet_valid, bus_d.header);
        end
    endtask

    task automatic test_flip();
        subs_t      s;
        words_t     w;
        words_t     wf;
        logic [4:0] want [2];
        int         fc [2];
        int         fb [2];
        s       = '0;
        s[0]    = 56'h00000000001A2B;
        w       = encode(24'h0D0282, s);
        want[0] = 5'b00100;
        want[1] = 5'b10000;
        fc[0] = 5;  fb[0] = 3;
        fc[1] = 26; fb[1] = 0;
        for (int k = 0; k < 2; k++) begin
            wf = w;
            wf[fc[k]][fb[k]] = ~wf[fc[k]][fb[k]];
            run_packet(wf);
            vectors++;
            if (bus.ecc_error !== want[k] || m_err !== want[k]) begin
                miscompares++;
                $display("FAIL flip%0d_err got %b model %b want %b",
                         k, bus.ecc_error, m_err, want[k]);
            end
            vectors++;
            if (bus.packet_valid !== 1'b1 || bus.header !== m_hdr) begin
                miscompares++;
                $display("FAIL flip%0d_pass got valid %b hdr %h want 1 %h",
                         k, bus.packet_valid, bus.header, m_hdr);
            end
            vectors++;
            if (bus_d.packet_valid !== 1'b0 || bus_d.header !== drop_hdr ||
                bus_d.ecc_error !== want[k]) begin
                miscompares++;
                $display("FAIL flip%0d_drop got valid %b hdr %h err %b want 0 %h %b",
                         k, bus_d.packet_valid, bus_d.header, bus_d.ecc_error,
                         drop_hdr, want[k]);
            end
        end
    endtask

    task automatic test_partial();
        int     p0;
        words_t w;
        bus.data_island_period = 1'b0;
        step();
        for (int c = 0; c < 15; c++) begin
            bus.data_island_period = 1'b1;
            bus.packet_data        = 9'($urandom);
            step();
        end
        vectors++;
        if (bus.counter !== 5'd15) begin
            miscompares++;
            $display("FAIL partial_counter got %0d want 15", bus.counter);
        end
        p0 = pulse_cnt;
        bus.data_island_period = 1'b0;
        step();
        vectors++;
        if (bus.counter !== 5'd0) begin
            miscompares++;
            $display("FAIL partial_restart got %0d want 0", bus.counter);
        end
        step();
        w = encode(24'($urandom), rand_subs());
        run_packet(w);
        bus.data_island_period = 1'b0;
        step();
        vectors++;
        if (pulse_cnt !== p0 + 1) begin
            miscompares++;
            $display("FAIL partial_pulses got %0d want %0d", pulse_cnt - p0, 1);
        end
        vectors++;
        if (bus.header !== m_hdr || bus.sub !== m_sub || bus.ecc_error !== 5'b0) begin
            miscompares++;
            $display("FAIL partial_full got hdr %h err %b want %h 00000",
                     bus.header, bus.ecc_error, m_hdr);
        end
    endtask

    task automatic test_back_to_back();
        words_t      w;
        logic [23:0] h [2];
        int          q0;
        q0 = pulse_cyc.size();
        for (int k = 0; k < 2; k++) begin
            h[k] = 24'($urandom) ^ 24'(k + 1);
            w    = encode(h[k], rand_subs());
            run_packet(w);
            vectors++;
            if (bus.packet_valid !== 1'b1 || bus.header !== h[k] || bus.sub !== m_sub) begin
                miscompares++;
                $display("FAIL b2b%0d got valid %b hdr %h want 1 %h",
                         k, bus.packet_valid, bus.header, h[k]);
            end
        end
        bus.data_island_period = 1'b0;
        step();
        vectors++;
        if (pulse_cyc.size() !== q0 + 2) begin
            miscompares++;
            $display("FAIL b2b_count got %0d want 2", pulse_cyc.size() - q0);
        end else if (pulse_cyc[q0+1] - pulse_cyc[q0] !== 32) begin
            miscompares++;
            $display("FAIL b2b_spacing got %0d want 32",
                     pulse_cyc[q0+1] - pulse_cyc[q0]);
        end
    endtask

    task automatic test_reset_mid();
        int     p0;
        words_t w;
        w = encode(24'($urandom), rand_subs());
        for (int c = 0; c < 20; c++) begin
            bus.data_island_period = 1'b1;
            bus.packet_data        = w[c];
            step();
        end
        vectors++;
        if (bus.counter !== 5'd20) begin
            miscompares++;
            $display("FAIL rstmid_pre got %0d want 20", bus.counter);
        end
        p0    = pulse_cnt;
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_reset();
        bus.data_island_period = 1'b0;
        vectors++;
        if (bus.counter !== 5'd0 || bus.header !== 24'h0 || bus.sub !== '0) begin
            miscompares++;
            $display("FAIL rstmid_clear got cnt %0d hdr %h want 0 0",
                     bus.counter, bus.header);
        end
        for (int i = 0; i < 16; i++) step();
        vectors++;
        if (pulse_cnt !== p0) begin
            miscompares++;
            $display("FAIL rstmid_pulse got %0d want 0", pulse_cnt - p0);
        end
        w = encode(24'($urandom), rand_subs());
        run_packet(w);
        vectors++;
        if (bus.packet_valid !== 1'b1 || bus.header !== m_hdr || bus.ecc_error !== 5'b0) begin
            miscompares++;
            $display("FAIL rstmid_after got valid %b hdr %h err %b want 1 %h 00000",
                     bus.packet_valid, bus.header, bus.ecc_error, m_hdr);
        end
    endtask

    task automatic test_random();
        words_t w;
        int     gap;
        for (int n = 0; n < 40; n++) begin
            w = encode(24'($urandom), rand_subs());
            if ($urandom_range(1, 0) == 1) begin
                int c;
                int b;
                c = $urandom_range(31, 0);
                b = $urandom_range(8, 0);
                w[c][b] = ~w[c][b];
            end
            run_packet(w);
            vectors++;
            if (bus.packet_valid !== 1'b1 || bus.header !== m_hdr ||
                bus.sub !== m_sub || bus.ecc_error !== m_err) begin
                miscompares++;
                $display("FAIL rand%0d got valid %b hdr %h err %b want 1 %h %b",
                         n, bus.packet_valid, bus.header, bus.ecc_error, m_hdr, m_err);
            end
            vectors++;
            if (bus_d.packet_valid !== (m_err == 5'b0) || bus_d.header !== drop_hdr ||
                bus_d.sub !== drop_sub || bus_d.ecc_error !== m_err) begin
                miscompares++;
                $display("FAIL rand%0d_drop got valid %b hdr %h err %b want %b %h %b",
                         n, bus_d.packet_valid, bus_d.header, bus_d.ecc_error,
                         (m_err == 5'b0), drop_hdr, m_err);
            end
            gap = $urandom_range(2, 0);
            for (int g = 0; g < gap; g++) begin
                bus.data_island_period = 1'b0;
                bus.packet_data        = 9'($urandom);
                step();
            end
        end
        bus.data_island_period = 1'b0;
        step();
    endtask

    initial begin
        bus.data_island_period = 1'b0;
        bus.packet_data        = '0;
        test_reset();
        test_null_packet();
        test_golden();
        test_flip();
        test_partial();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
